// File: rtl/alarm_sequencer_pkg.sv
// Shared definitions for the alarm sequencer: state encodings, default
// prescale constant (also used by the tone generator) and a sizing helper.
package alarm_sequencer_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEEP  = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  // 12 MHz system clock -> 12000 cycles per millisecond
  localparam int DEF_CLK_PER_MS = 12000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alarm_sequencer_ms_tick_gen.sv
// Reusable millisecond prescaler: counts 0..CLK_PER_MS-1 and pulses tick on
// the terminal count. clr restarts the millisecond from zero.
module ms_tick_gen
  import alarm_sequencer_pkg::*;
#(
  parameter int CLK_PER_MS = DEF_CLK_PER_MS
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  logic [W-1:0] cnt;

  assign tick = (32'(cnt) == 32'(CLK_PER_MS - 1));

  // Free-running modulo-CLK_PER_MS counter, restartable by clr
  always_ff @(posedge CLK) begin
    if (RST || clr) cnt <= '0;
    else if (tick)  cnt <= '0;
    else            cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Beep-pattern controller: drives the tone generator enable with bursts of
// BEEPS beeps separated by pauses, BURSTS times (0 = until stopped).
module alarm_sequencer
  import alarm_sequencer_pkg::*;
#(
  parameter int CLK_PER_MS = DEF_CLK_PER_MS,
  parameter int BEEP_MS    = 200,
  parameter int GAP_MS     = 100,
  parameter int BEEPS      = 3,
  parameter int PAUSE_MS   = 800,
  parameter int BURSTS     = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic trigger,
  input  logic stop,
  output logic alarm_en,
  output logic busy,
  output logic done
);

  localparam int MAX_MS   = max3(BEEP_MS, GAP_MS, PAUSE_MS);
  localparam int MS_W     = $clog2(MAX_MS + 1);
  localparam int BEEP_W   = $clog2(BEEPS + 1);
  // BURSTS = 0 never counts, but keep a legal 1-bit counter
  localparam int BURST_M  = (BURSTS == 0) ? 1 : BURSTS;
  localparam int BURST_W  = $clog2(BURST_M + 1);

  logic [1:0]         state, nxt;
  logic [MS_W-1:0]    ms_cnt;
  logic [BEEP_W-1:0]  beep_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic [31:0]        dur;
  logic               tick, clr, ms_last, last_beep, last_burst, done_nxt;

  // Prescaler held cleared while idle and restarted on every state entry,
  // so each state lasts exactly dur*CLK_PER_MS cycles
  assign clr = (state == S_IDLE) || (nxt != state);

  ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (clr),
    .tick (tick)
  );

  // Duration of the current state in milliseconds
  always_comb begin
    dur = 32'(BEEP_MS);
    case (state)
      S_GAP:   dur = 32'(GAP_MS);
      S_PAUSE: dur = 32'(PAUSE_MS);
      default: dur = 32'(BEEP_MS);
    endcase
  end

  assign ms_last    = tick && (state != S_IDLE) && (32'(ms_cnt) == dur - 32'd1);
  assign last_beep  = (32'(beep_cnt) == 32'(BEEPS - 1));
  assign last_burst = (BURSTS != 0) && (32'(burst_cnt) == 32'(BURST_M - 1));

  // Next-state logic; stop dominates everything including trigger
  always_comb begin
    nxt      = state;
    done_nxt = 1'b0;
    if (stop) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (trigger) nxt = S_BEEP;
        S_BEEP:  if (ms_last) begin
                   if (!last_beep)     nxt = S_GAP;
                   else if (last_burst) begin
                     nxt      = S_IDLE;
                     done_nxt = 1'b1;
                   end else            nxt = S_PAUSE;
                 end
        S_GAP:   if (ms_last) nxt = S_BEEP;
        S_PAUSE: if (ms_last) nxt = S_BEEP;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      ms_cnt    <= '0;
      beep_cnt  <= '0;
      burst_cnt <= '0;
      alarm_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= nxt;
      alarm_en <= (nxt == S_BEEP);
      busy     <= (nxt != S_IDLE);
      done     <= done_nxt;

      if (clr)       ms_cnt <= '0;
      else if (tick) ms_cnt <= ms_cnt + 1'b1;

      if (nxt == S_IDLE) begin
        beep_cnt  <= '0;
        burst_cnt <= '0;
      end else if (state == S_BEEP && nxt == S_GAP) begin
        beep_cnt <= beep_cnt + 1'b1;
      end else if (state == S_PAUSE && nxt == S_BEEP) begin
        beep_cnt <= '0;
        if (BURSTS != 0) burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

endmodule
